mem_access_sequencer: RTL and testbench

MEM-stage controller that sequences one data-memory access per load/store over a valid/ready request channel and a valid-only response channel.
- Stalls the pipeline while the access is outstanding.
- Captures load data and presents the final MEM-stage result (load data or ALU result) to the MEM result register.
- Non-memory instructions pass through with zero added latency.

---
 rtl/mem_access_sequencer_pkg.sv | 10 +
 rtl/mem_access_watchdog.sv | 31 +++
 rtl/mem_access_sequencer.sv | 142 ++++++++++++++
 tb/tb_mem_access_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_sequencer_pkg.sv
// Shared instruction-class encodings for the MEM-stage access sequencer.
package mem_access_sequencer_pkg;
  localparam int INSTR_W = 5;
  localparam logic [INSTR_W-1:0] INSTR_LOAD  = 5'd1;
  localparam logic [INSTR_W-1:0] INSTR_STORE = 5'd2;

  function automatic logic is_mem_type(input logic [INSTR_W-1:0] t);
    return (t == INSTR_LOAD) || (t == INSTR_STORE);
  endfunction
endpackage

// File: rtl/mem_access_watchdog.sv
// Cycle counter that flags an outstanding memory access as timed out.
module mem_access_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic active_i,
  output logic timeout_o
);
  localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (active_i && (cnt_q != '1))
      cnt_d = cnt_q + TO_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Counter shows cycles already spent, so the limit hits in the last allowed cycle.
  assign timeout_o = active_i && (cnt_q >= LIMIT);
endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage load/store sequencer with pipeline stall and result mux.
// Optional watchdog abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid_i,
  input  logic [INSTR_W-1:0] instr_type_i,
  input  logic [DATA_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  store_data_i,
  input  logic [DATA_W-1:0]  alu_result_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic               mem_req_we_o,
  output logic [DATA_W-1:0]  mem_req_addr_o,
  output logic [DATA_W-1:0]  mem_req_wdata_o,
  input  logic               mem_resp_valid_i,
  input  logic [DATA_W-1:0]  mem_resp_rdata_i,
  output logic               stall_o,
  output logic               result_valid_o,
  output logic [DATA_W-1:0]  exe_result_o,
  output logic               mem_error_o
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic                we_q, we_d, err_q, err_d;
  logic                is_mem, wd_clear, wd_active, wd_timeout;

  assign is_mem = instr_valid_i && is_mem_type(instr_type_i);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    we_d            = we_q;
    rdata_d         = rdata_q;
    err_d           = 1'b0;
    mem_req_valid_o = 1'b0;
    stall_o         = 1'b0;
    result_valid_o  = 1'b0;
    exe_result_o    = alu_result_i;
    wd_clear        = 1'b0;
    wd_active       = 1'b0;
    case (state_q)
      S_IDLE: begin
        result_valid_o = instr_valid_i && !is_mem;
        if (is_mem) begin
          stall_o  = 1'b1;
          addr_d   = addr_i;
          wdata_d  = store_data_i;
          we_d     = (instr_type_i == INSTR_STORE);
          wd_clear = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        stall_o         = 1'b1;
        mem_req_valid_o = 1'b1;
        wd_active       = 1'b1;
        if (mem_req_ready_i) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (wd_timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        stall_o   = 1'b1;
        wd_active = 1'b1;
        // A response in the timeout cycle still completes normally.
        if (mem_resp_valid_i) begin
          rdata_d = mem_resp_rdata_i;
          state_d = S_DONE;
        end else if (wd_timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_valid_o = 1'b1;
        exe_result_o   = we_q ? alu_result_i : rdata_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_we_o    = we_q;
  assign mem_req_addr_o  = addr_q;
  assign mem_req_wdata_o = wdata_q;

`ifdef MEM_TIMEOUT_EN
  mem_access_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_CNT_W       (TO_CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (wd_clear),
    .active_i  (wd_active),
    .timeout_o (wd_timeout)
  );
  assign mem_error_o = err_q;
`else
  logic unused_wd;
  assign wd_timeout  = 1'b0;
  assign mem_error_o = 1'b0;
  assign unused_wd   = ^{wd_clear, wd_active, err_q, TIMEOUT_CYCLES, TO_CNT_W};
`endif
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized self-checking bench for mem_access_sequencer (transaction timeline model).
module tb_mem_access_sequencer;
  import mem_access_sequencer_pkg::*;
  localparam int W = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               instr_valid_i = 1'b0;
  logic [INSTR_W-1:0] instr_type_i = '0;
  logic [W-1:0]       addr_i = '0, store_data_i = '0, alu_result_i = '0;
  logic               mem_req_ready_i = 1'b0, mem_resp_valid_i = 1'b0;
  logic [W-1:0]       mem_resp_rdata_i = '0;
  logic               mem_req_valid_o, mem_req_we_o, stall_o, result_valid_o, mem_error_o;
  logic [W-1:0]       mem_req_addr_o, mem_req_wdata_o, exe_result_o;

  mem_access_sequencer #(.DATA_W(W), .TIMEOUT_CYCLES(8), .TO_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i), .instr_type_i(instr_type_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .alu_result_i(alu_result_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_rdata_i(mem_resp_rdata_i), .stall_o(stall_o), .result_valid_o(result_valid_o),
    .exe_result_o(exe_result_o), .mem_error_o(mem_error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, rv, reqv, we, err;
    logic [W-1:0] exe, addr, wdata;
  } exp_t;

  exp_t expq[$];
  exp_t ecur;
  int n_cmp = 0, n_bad = 0;
  int stall_run = 0, req_run = 0, last_stall = -1, last_req = -1;
  logic [W-1:0] last_exe = '0;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic st, input logic rv, input logic rq, input logic [W-1:0] exe);
    exp_t e;
    e.stall = st; e.rv = rv; e.reqv = rq; e.exe = exe;
    e.we = 1'b0; e.addr = '0; e.wdata = '0; e.err = 1'b0;
    return e;
  endfunction

  // Per-cycle compare against the timeline expectations, plus run-length bookkeeping.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ecur = expq.pop_front();
      chk_b("stall", stall_o, ecur.stall);
      chk_b("result_valid", result_valid_o, ecur.rv);
      chk_b("mem_req_valid", mem_req_valid_o, ecur.reqv);
      chk_b("mem_error", mem_error_o, ecur.err);
      if (ecur.rv) chk_w("exe_result", exe_result_o, ecur.exe);
      if (ecur.reqv) begin
        chk_b("mem_req_we", mem_req_we_o, ecur.we);
        chk_w("mem_req_addr", mem_req_addr_o, ecur.addr);
        chk_w("mem_req_wdata", mem_req_wdata_o, ecur.wdata);
      end
    end
    if (!rst_n) begin
      stall_run = 0; req_run = 0;
    end else if (result_valid_o) begin
      last_stall = stall_run; last_req = req_run; last_exe = exe_result_o;
      stall_run = 0; req_run = 0;
    end else begin
      stall_run += int'(stall_o);
      req_run   += int'(mem_req_valid_o);
    end
  end

  task automatic step(input exp_t e);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic garble();
    instr_valid_i = 1'($urandom_range(0, 1));
    instr_type_i  = INSTR_W'($urandom_range(0, 31));
    addr_i        = $urandom;
    store_data_i  = $urandom;
    alu_result_i  = $urandom;
  endtask

  // One instruction: the expected outputs of every cycle follow from the handshake timing.
  task automatic run_op(input logic v, input logic [INSTR_W-1:0] ty, input logic [W-1:0] a,
                        input logic [W-1:0] sd, input logic [W-1:0] alu, input logic [W-1:0] rd,
                        input int rdy_wait, input int resp_wait);
    logic mem, st;
    exp_t e;
    mem = v && (ty == INSTR_LOAD || ty == INSTR_STORE);
    st  = (ty == INSTR_STORE);
    instr_valid_i = v; instr_type_i = ty; addr_i = a; store_data_i = sd; alu_result_i = alu;
    mem_req_ready_i = 1'($urandom_range(0, 1));
    mem_resp_valid_i = 1'($urandom_range(0, 1));
    mem_resp_rdata_i = $urandom;
    step(mk(mem, v && !mem, 1'b0, alu));
    if (!mem) return;
    for (int i = 0; i <= rdy_wait; i++) begin
      garble();
      mem_req_ready_i  = (i == rdy_wait);
      mem_resp_valid_i = 1'($urandom_range(0, 1));
      e = mk(1'b1, 1'b0, 1'b1, '0);
      e.we = st; e.addr = a; e.wdata = sd;
      step(e);
    end
    if (!st) begin
      for (int j = 1; j <= resp_wait; j++) begin
        garble();
        mem_req_ready_i  = 1'($urandom_range(0, 1));
        mem_resp_valid_i = (j == resp_wait);
        mem_resp_rdata_i = (j == resp_wait) ? rd : $urandom;
        step(mk(1'b1, 1'b0, 1'b0, '0));
      end
    end
    instr_valid_i = 1'($urandom_range(0, 1));
    instr_type_i = ty; addr_i = a; store_data_i = sd; alu_result_i = alu;
    mem_req_ready_i = 1'($urandom_range(0, 1));
    mem_resp_valid_i = 1'b0;
    mem_resp_rdata_i = $urandom;
    step(mk(1'b0, 1'b1, 1'b0, st ? alu : rd));
  endtask

  initial begin
    logic [INSTR_W-1:0] ty;
    #3;
    chk_b("reset stall", stall_o, 1'b0);
    chk_b("reset result_valid", result_valid_o, 1'b0);
    chk_b("reset mem_req_valid", mem_req_valid_o, 1'b0);
    chk_b("reset mem_req_we", mem_req_we_o, 1'b0);
    chk_w("reset mem_req_addr", mem_req_addr_o, 32'h0);
    chk_w("reset mem_req_wdata", mem_req_wdata_o, 32'h0);
    chk_b("reset mem_error", mem_error_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(1'b1, 5'd7, 32'h0, 32'h0, 32'h1234, 32'h0, 0, 1);
    chk_w("alu_op exe", last_exe, 32'h1234);
    chk_w("alu_op stalls", 32'(last_stall), 32'd0);

    run_op(1'b1, INSTR_LOAD, 32'h100, 32'h0, 32'h5555, 32'hDEADBEEF, 0, 1);
    chk_w("load exe", last_exe, 32'hDEADBEEF);
    chk_w("load stalls", 32'(last_stall), 32'd3);

    run_op(1'b1, INSTR_STORE, 32'h40, 32'hCAFE, 32'h7777, 32'h0, 4, 1);
    chk_w("store exe", last_exe, 32'h7777);
    chk_w("store req cycles", 32'(last_req), 32'd5);

    run_op(1'b1, INSTR_LOAD, 32'h200, 32'h0, 32'h1, 32'hA1A1A1A1, 1, 2);
    run_op(1'b1, INSTR_LOAD, 32'h204, 32'h0, 32'h2, 32'hB2B2B2B2, 0, 1);
    chk_w("b2b second exe", last_exe, 32'hB2B2B2B2);

    // Reset asserted while a load waits for its response.
    instr_valid_i = 1'b1; instr_type_i = INSTR_LOAD; addr_i = 32'h300;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    step(mk(1'b1, 1'b0, 1'b0, '0));
    mem_req_ready_i = 1'b1;
    begin
      exp_t e;
      e = mk(1'b1, 1'b0, 1'b1, '0); e.addr = 32'h300;
      step(e);
    end
    mem_req_ready_i = 1'b0;
    #2;
    rst_n = 1'b0; instr_valid_i = 1'b0;
    #1;
    chk_b("async reset mem_req_valid", mem_req_valid_o, 1'b0);
    chk_b("async reset stall", stall_o, 1'b0);
    chk_w("async reset addr", mem_req_addr_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid_i = 1'b1; mem_resp_rdata_i = 32'h99999999;
    step(mk(1'b0, 1'b0, 1'b0, '0));
    mem_resp_valid_i = 1'b0;
    step(mk(1'b0, 1'b0, 1'b0, '0));

`ifdef MEM_TIMEOUT_EN
    instr_valid_i = 1'b1; instr_type_i = INSTR_LOAD; addr_i = 32'h400; alu_result_i = 32'h3;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    step(mk(1'b1, 1'b0, 1'b0, '0));
    mem_req_ready_i = 1'b1;
    begin
      exp_t e;
      e = mk(1'b1, 1'b0, 1'b1, '0); e.addr = 32'h400;
      step(e);
      mem_req_ready_i = 1'b0;
      for (int k = 0; k < 7; k++) step(mk(1'b1, 1'b0, 1'b0, '0));
      e = mk(1'b0, 1'b1, 1'b0, 32'h0); e.err = 1'b1;
      instr_valid_i = 1'b0;
      step(e);
    end
    step(mk(1'b0, 1'b0, 1'b0, '0));
    chk_w("timeout exe", last_exe, 32'h0);
    chk_w("timeout stalls", 32'(last_stall), 32'd9);
`endif

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0:       ty = INSTR_LOAD;
        1:       ty = INSTR_STORE;
        default: ty = INSTR_W'($urandom_range(0, 31));
      endcase
      run_op(($urandom_range(0, 7) != 0), ty, $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3));
    end
    instr_valid_i = 1'b0;
    step(mk(1'b0, 1'b0, 1'b0, '0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
